if_fetch_buffer: RTL and testbench

- Parametrised next-generation instruction-fetch stage.
- Drives a valid/ready instruction-memory request port and accepts in-order responses of variable latency.
- Buffers fetched instructions with their PCs in a small queue and presents them to ID through a valid/ready handshake.
- Supports branch redirect with a full flush, and discards stale in-flight responses after a redirect.

---
 rtl/if_fetch_buffer_pkg.sv | 8 +
 rtl/if_fetch_buffer_chk.sv | 19 +
 rtl/if_fetch_queue.sv | 85 ++++++++
 rtl/if_fetch_buffer.sv | 132 +++++++++++++
 tb/tb_if_fetch_buffer.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/if_fetch_buffer_pkg.sv
// Shared constants for the instruction-fetch buffer slice.
package if_fetch_buffer_pkg;

    localparam logic [31:0] INSTR_NOP   = 32'h0000_0013;
    localparam int unsigned WORD_STRIDE = 4;
    localparam logic        RST_ACTIVE  = 1'b1;

endpackage

// File: rtl/if_fetch_buffer_chk.sv
// Protocol checker: a memory response must always have a request to answer.
module if_fetch_buffer_chk
    import if_fetch_buffer_pkg::*;
#(
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rsp_valid,
    input  logic [PTR_W-1:0] inflight,
    input  logic [PTR_W-1:0] drop_cnt
);

    rsp_without_request: assert property (
        @(posedge clk) disable iff (rst == RST_ACTIVE)
        !(rsp_valid && (inflight == '0) && (drop_cnt == '0))
    );

endmodule

// File: rtl/if_fetch_queue.sv
// Circular buffer of fetched instructions with separate allocate, fill and pop
// pointers; entries are reserved at request time and filled when data returns.
module if_fetch_queue
    import if_fetch_buffer_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     alloc,
    input  logic [ADDR_W-1:0]        alloc_pc,
    input  logic                     fill,
    input  logic [DATA_W-1:0]        fill_data,
    input  logic                     pop,
    output logic [$clog2(DEPTH):0]   alloc_cnt,
    output logic [$clog2(DEPTH):0]   inflight,
    output logic                     head_filled,
    output logic [ADDR_W-1:0]        head_pc,
    output logic [DATA_W-1:0]        head_instr
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W:0] PTR_ONE = {{IDX_W{1'b0}}, 1'b1};

    logic [IDX_W:0]      wr_ptr_r;
    logic [IDX_W:0]      fill_ptr_r;
    logic [IDX_W:0]      rd_ptr_r;
    logic [ADDR_W-1:0]   pc_r    [DEPTH];
    logic [DATA_W-1:0]   instr_r [DEPTH];
    logic [DEPTH-1:0]    filled_r;

    logic [IDX_W-1:0]    wr_idx_s;
    logic [IDX_W-1:0]    fill_idx_s;
    logic [IDX_W-1:0]    rd_idx_s;

    // Pointer index extraction and head/occupancy views.
    always_comb begin
        wr_idx_s    = wr_ptr_r[IDX_W-1:0];
        fill_idx_s  = fill_ptr_r[IDX_W-1:0];
        rd_idx_s    = rd_ptr_r[IDX_W-1:0];
        alloc_cnt   = wr_ptr_r - rd_ptr_r;
        inflight    = wr_ptr_r - fill_ptr_r;
        head_filled = filled_r[rd_idx_s];
        head_pc     = pc_r[rd_idx_s];
        head_instr  = instr_r[rd_idx_s];
    end

    // Pointer and entry storage; a flush discards every allocated entry at once.
    always_ff @(posedge clk) begin
        if (rst == RST_ACTIVE) begin
            wr_ptr_r   <= '0;
            fill_ptr_r <= '0;
            rd_ptr_r   <= '0;
            filled_r   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_r[i]    <= '0;
                instr_r[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr_r   <= wr_ptr_r;
            fill_ptr_r <= wr_ptr_r;
            filled_r   <= '0;
        end else begin
            if (pop) begin
                filled_r[rd_idx_s] <= 1'b0;
                rd_ptr_r           <= rd_ptr_r + PTR_ONE;
            end
            if (alloc) begin
                pc_r[wr_idx_s]     <= alloc_pc;
                filled_r[wr_idx_s] <= 1'b0;
                wr_ptr_r           <= wr_ptr_r + PTR_ONE;
            end
            // The fill slot is never the pop or allocate slot: it is allocated but unfilled.
            if (fill) begin
                instr_r[fill_idx_s]  <= fill_data;
                filled_r[fill_idx_s] <= 1'b1;
                fill_ptr_r           <= fill_ptr_r + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/if_fetch_buffer.sv
// Instruction-fetch stage: issues sequential fetches, tracks stale responses
// after a redirect, and hands buffered instructions to ID.
module if_fetch_buffer
    import if_fetch_buffer_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [ADDR_W-1:0] id_pc,
    output logic [DATA_W-1:0] id_instr
);

    localparam int                PTR_W      = $clog2(DEPTH) + 1;
    localparam logic [ADDR_W-1:0] PC_STRIDE  = ADDR_W'(WORD_STRIDE);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(WORD_STRIDE - 1));
    localparam logic [PTR_W:0]    DEPTH_LIM  = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0]  CNT_ONE    = {{(PTR_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0] fetch_pc_r;
    logic [PTR_W-1:0]  drop_cnt_r;

    logic [PTR_W-1:0]  alloc_cnt_s;
    logic [PTR_W-1:0]  inflight_s;
    logic [PTR_W:0]    budget_s;
    logic [PTR_W-1:0]  drop_redirect_s;
    logic              in_reset_s;
    logic              req_valid_s;
    logic              req_fire_s;
    logic              rsp_live_s;
    logic              fill_s;
    logic              pop_s;
    logic              id_valid_s;
    logic              head_filled_s;
    logic [ADDR_W-1:0] head_pc_s;
    logic [DATA_W-1:0] head_instr_s;

    // Request gate, response routing and ID handshake.
    always_comb begin
        in_reset_s  = (rst == RST_ACTIVE);
        // Stale requests still occupy memory slots, so they count against the budget.
        budget_s    = {1'b0, alloc_cnt_s} + {1'b0, drop_cnt_r};
        req_valid_s = !in_reset_s && !redirect_valid && (budget_s < DEPTH_LIM);
        req_fire_s  = req_valid_s && imem_req_ready;
        rsp_live_s  = imem_rsp_valid && ((drop_cnt_r != '0) || (inflight_s != '0));
        fill_s      = imem_rsp_valid && (drop_cnt_r == '0) && (inflight_s != '0)
                      && !redirect_valid && !in_reset_s;
        id_valid_s  = head_filled_s && (alloc_cnt_s != '0) && !redirect_valid && !in_reset_s;
        pop_s       = id_valid_s && id_ready;
        if (rsp_live_s) begin
            drop_redirect_s = drop_cnt_r + inflight_s - CNT_ONE;
        end else begin
            drop_redirect_s = drop_cnt_r + inflight_s;
        end
    end

    // Output drive; reset forces the documented idle values immediately.
    always_comb begin
        imem_req_valid = req_valid_s;
        id_valid       = id_valid_s;
        if (in_reset_s) begin
            imem_req_addr = RESET_PC;
            id_pc         = '0;
            id_instr      = '0;
        end else begin
            imem_req_addr = fetch_pc_r;
            id_pc         = head_pc_s;
            id_instr      = head_instr_s;
        end
    end

    // Fetch PC and count of responses still owed to flushed requests.
    always_ff @(posedge clk) begin
        if (in_reset_s) begin
            fetch_pc_r <= RESET_PC;
            drop_cnt_r <= '0;
        end else if (redirect_valid) begin
            fetch_pc_r <= redirect_pc & ALIGN_MASK;
            drop_cnt_r <= drop_redirect_s;
        end else begin
            if (req_fire_s) begin
                fetch_pc_r <= fetch_pc_r + PC_STRIDE;
            end
            if (rsp_live_s && (drop_cnt_r != '0)) begin
                drop_cnt_r <= drop_cnt_r - CNT_ONE;
            end
        end
    end

    if_fetch_queue #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_queue (
        .clk         (clk),
        .rst         (rst),
        .flush       (redirect_valid),
        .alloc       (req_fire_s),
        .alloc_pc    (fetch_pc_r),
        .fill        (fill_s),
        .fill_data   (imem_rsp_data),
        .pop         (pop_s),
        .alloc_cnt   (alloc_cnt_s),
        .inflight    (inflight_s),
        .head_filled (head_filled_s),
        .head_pc     (head_pc_s),
        .head_instr  (head_instr_s)
    );

    if_fetch_buffer_chk #(
        .PTR_W (PTR_W)
    ) u_chk (
        .clk       (clk),
        .rst       (rst),
        .rsp_valid (imem_rsp_valid),
        .inflight  (inflight_s),
        .drop_cnt  (drop_cnt_r)
    );

endmodule

// File: tb/tb_if_fetch_buffer.sv
// Self-checking bench for if_fetch_buffer: memory model, PC/instruction
// scoreboard, table-driven redirect vectors and hand-written corner sequences.
module tb_if_fetch_buffer;

    localparam int DEPTH = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_instr;

    if_fetch_buffer #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_instr       (id_instr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    typedef struct {
        int          lat;
        int          rdy_pct;
        int          idr_pct;
        logic [31:0] target;
        logic [31:0] exp_addr;
    } vec_t;

    mreq_t       mem_q[$];
    logic [31:0] exp_q[$];
    vec_t        vecs[6];

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          lat = 1;
    bit          mem_hold = 1'b0;
    int          accepts = 0;
    logic [31:0] model_pc = RESET_PC;
    bit          mark_armed = 1'b0;
    logic [31:0] mark_pc = 32'h0;

    logic        s_req_valid;
    logic [31:0] s_req_addr;
    logic        s_id_valid;
    logic [31:0] s_id_pc;
    logic [31:0] s_id_instr;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: sample and score at negedge, then drive the memory response.
    task automatic tick();
        @(negedge clk);
        s_req_valid = imem_req_valid;
        s_req_addr  = imem_req_addr;
        s_id_valid  = id_valid;
        s_id_pc     = id_pc;
        s_id_instr  = id_instr;
        if (rst) begin
            mem_q.delete();
            exp_q.delete();
            model_pc = RESET_PC;
        end else begin
            if (id_valid) begin
                if (exp_q.size() == 0) begin
                    chk("stale_id_valid", {32'h0, id_pc}, 64'hDEAD);
                end else begin
                    chk("id_pc", {32'h0, id_pc}, {32'h0, exp_q[0]});
                    chk("id_instr", {32'h0, id_instr}, {32'h0, instr_of(exp_q[0])});
                    if (id_ready) begin
                        if (mark_armed) begin
                            mark_pc    = exp_q[0];
                            mark_armed = 1'b0;
                        end
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (imem_req_valid) chk("req_addr", {32'h0, imem_req_addr}, {32'h0, model_pc});
            if (imem_req_valid && imem_req_ready) begin
                mem_q.push_back('{addr: model_pc, due: cyc + lat});
                exp_q.push_back(model_pc);
                model_pc = model_pc + 32'd4;
                accepts++;
            end
            if (redirect_valid) begin
                chk("redir_no_req", {63'h0, imem_req_valid}, 64'h0);
                chk("redir_no_id", {63'h0, id_valid}, 64'h0);
                exp_q.delete();
                model_pc = {redirect_pc[31:2], 2'b00};
            end
            chk("outstanding_le_depth", {63'h0, mem_q.size() <= DEPTH}, 64'h1);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (!mem_hold && (mem_q.size() > 0) && (mem_q[0].due <= cyc)) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = instr_of(mem_q[0].addr);
            void'(mem_q.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        accepts = 0;
    endtask

    initial begin
        vecs[0] = '{1, 100, 100, 32'h0000_0103, 32'h0000_0100};
        vecs[1] = '{2,  70,  60, 32'h0000_0FFF, 32'h0000_0FFC};
        vecs[2] = '{3,  50,  80, 32'h8000_0002, 32'h8000_0000};
        vecs[3] = '{1,  90,  40, 32'hFFFF_FFF9, 32'hFFFF_FFF8};
        vecs[4] = '{4,  60,  90, 32'h1234_5678, 32'h1234_5678};
        vecs[5] = '{2, 100,  50, 32'hFFFF_FFFF, 32'hFFFF_FFFC};

        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = 32'h0;
        id_ready = 1'b1;

        // Reset state and steady streaming with 1-cycle memory.
        tick();
        tick();
        chk("rst_req_valid", {63'h0, s_req_valid}, 64'h0);
        chk("rst_id_valid", {63'h0, s_id_valid}, 64'h0);
        chk("rst_req_addr", {32'h0, s_req_addr}, {32'h0, RESET_PC});
        chk("rst_id_pc", {32'h0, s_id_pc}, 64'h0);
        chk("rst_id_instr", {32'h0, s_id_instr}, 64'h0);
        rst = 1'b0;
        tick();
        chk("first_req_valid", {63'h0, s_req_valid}, 64'h1);
        chk("first_req_addr", {32'h0, s_req_addr}, {32'h0, RESET_PC});
        chk("c0_id_valid", {63'h0, s_id_valid}, 64'h0);
        tick();
        chk("c1_id_valid", {63'h0, s_id_valid}, 64'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stream_id_valid", {63'h0, s_id_valid}, 64'h1);
            chk("stream_id_pc", {32'h0, s_id_pc}, 64'(i * 4));
        end

        // Memory stall: address held, nothing allocated, ID drains then idles.
        begin
            logic [31:0] held;
            int          acc0;
            imem_req_ready = 1'b0;
            acc0 = accepts;
            tick();
            held = s_req_addr;
            chk("stall_addr0", {32'h0, held}, 64'h18);
            for (int i = 1; i < 5; i++) begin
                tick();
                chk("stall_addr_held", {32'h0, s_req_addr}, {32'h0, held});
                chk("stall_req_valid", {63'h0, s_req_valid}, 64'h1);
                if (i >= 2) chk("stall_id_idle", {63'h0, s_id_valid}, 64'h0);
            end
            chk("stall_no_alloc", 64'(accepts), 64'(acc0));
            imem_req_ready = 1'b1;
        end

        // ID back-pressure: exactly DEPTH requests, then resume after the pop.
        id_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 8; i++) tick();
        chk("full_accepts", 64'(accepts), 64'(DEPTH));
        chk("full_req_valid", {63'h0, s_req_valid}, 64'h0);
        chk("full_id_valid", {63'h0, s_id_valid}, 64'h1);
        chk("full_id_pc", {32'h0, s_id_pc}, 64'h0);
        id_ready = 1'b1;
        tick();
        chk("pop_cycle_req_valid", {63'h0, s_req_valid}, 64'h0);
        tick();
        chk("resume_req_valid", {63'h0, s_req_valid}, 64'h1);
        chk("resume_req_addr", {32'h0, s_req_addr}, 64'h10);

        // Redirect with two requests in flight; stale responses must be dropped.
        lat = 1;
        do_reset();
        tick();
        tick();
        mem_hold = 1'b1;
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0103;
        tick();
        redirect_valid = 1'b0;
        mem_hold = 1'b0;
        mark_armed = 1'b1;
        tick();
        chk("after_redir_req_valid", {63'h0, s_req_valid}, 64'h1);
        chk("after_redir_req_addr", {32'h0, s_req_addr}, 64'h100);
        for (int i = 0; i < 10; i++) tick();
        chk("redir_popped", {63'h0, mark_armed}, 64'h0);
        chk("redir_first_pc", {32'h0, mark_pc}, 64'h100);

        // Redirect coinciding with a response, then a second redirect next cycle.
        lat = 2;
        do_reset();
        for (int i = 0; i < 6; i++) tick();
        begin
            int guard = 0;
            while (!imem_rsp_valid && guard < 4) begin
                tick();
                guard++;
            end
            chk("rsp_seen_for_redirect", {63'h0, imem_rsp_valid}, 64'h1);
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_2000;
        tick();
        redirect_pc = 32'h0000_3002;
        tick();
        redirect_valid = 1'b0;
        mark_armed = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        chk("double_redir_popped", {63'h0, mark_armed}, 64'h0);
        chk("double_redir_first_pc", {32'h0, mark_pc}, 64'h3000);

        // Reset mid-stream with three entries buffered and one response late.
        lat = 1;
        id_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        tick();
        chk("midrst_id_valid", {63'h0, s_id_valid}, 64'h0);
        chk("midrst_req_addr", {32'h0, s_req_addr}, {32'h0, RESET_PC});
        chk("midrst_id_pc", {32'h0, s_id_pc}, 64'h0);
        rst = 1'b0;
        id_ready = 1'b1;
        accepts = 0;
        mark_armed = 1'b1;
        tick();
        chk("midrst_no_late_rsp", {63'h0, s_id_valid}, 64'h0);
        for (int i = 0; i < 6; i++) tick();
        chk("midrst_first_pc", {32'h0, mark_pc}, {32'h0, RESET_PC});

        // Table-driven redirects under random readiness and varying latency.
        for (int v = 0; v < 6; v++) begin
            lat = vecs[v].lat;
            for (int i = 0; i < 20; i++) begin
                imem_req_ready = ($urandom_range(99) < vecs[v].rdy_pct);
                id_ready = ($urandom_range(99) < vecs[v].idr_pct);
                tick();
            end
            redirect_valid = 1'b1;
            redirect_pc = vecs[v].target;
            tick();
            redirect_valid = 1'b0;
            mark_armed = 1'b1;
            tick();
            chk("vec_redir_addr", {32'h0, s_req_addr}, {32'h0, vecs[v].exp_addr});
            for (int i = 0; i < 30; i++) begin
                imem_req_ready = ($urandom_range(99) < vecs[v].rdy_pct);
                id_ready = ($urandom_range(99) < vecs[v].idr_pct);
                tick();
            end
            imem_req_ready = 1'b1;
            id_ready = 1'b1;
            for (int i = 0; i < 12; i++) tick();
            chk("vec_popped", {63'h0, mark_armed}, 64'h0);
            chk("vec_first_pc", {32'h0, mark_pc}, {32'h0, vecs[v].exp_addr});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
